// File: rtl/lfsr_pkg.sv
// Shared types and helpers for the LFSR round-robin arbiter.
// 4-bit maximal-length LFSR, period 15.
package lfsr_pkg;

  localparam int LFSR_W = 4;
  localparam logic [LFSR_W-1:0] SEED0_DEF = 4'b1000;

  typedef enum logic [1:0] {
    IDLE,
    STEP,
    GRANT
  } state_t;

  function automatic logic [LFSR_W-1:0] lfsr_next(
    input logic [LFSR_W-1:0] v
  );
    return {v[1] ^ v[0], v[3:1]};
  endfunction

endpackage

// File: rtl/lfsr_step_core.sv
// LFSR state register with load and step enable.
// A load takes priority over a shift in the same cycle.
module lfsr_step_core
  import lfsr_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED0 = SEED0_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [LFSR_W-1:0] load_val,
  input  logic              en,
  output logic [LFSR_W-1:0] q
);

  // lfsr register: reset to seed, load wins over step
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= SEED0;
    end else if (load) begin
      q <= load_val;
    end else if (en) begin
      q <= lfsr_next(q);
    end
  end

endmodule

// File: rtl/lfsr_rr_arbiter.sv
// Round-robin arbiter sharing one LFSR among requesters.
// Each grant is preceded by STEPS shifts to decorrelate values.
module lfsr_rr_arbiter
  import lfsr_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int STEPS = 3,
  parameter logic [LFSR_W-1:0] SEED0 = SEED0_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_REQ-1:0]  req,
  output logic [N_REQ-1:0]  gnt,
  output logic [LFSR_W-1:0] rnd_out,
  output logic              rnd_valid,
  input  logic              seed_we,
  input  logic [LFSR_W-1:0] seed,
  output logic              seed_err,
  output logic              busy
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = 4;

  state_t            state;
  state_t            state_n;
  logic [PW-1:0]     rr_ptr;
  logic [PW-1:0]     ptr_n;
  logic [PW-1:0]     winner;
  logic [PW-1:0]     win_n;
  logic [PW-1:0]     pick;
  logic [PW:0]       idx;
  logic              found;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_n;
  logic [LFSR_W-1:0] lfsr;
  logic [LFSR_W-1:0] load_val;
  logic [LFSR_W-1:0] rnd_q;
  logic              load;
  logic              shift;
  logic              err_n;

  lfsr_step_core #(
    .SEED0(SEED0)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .load_val(load_val),
    .en      (shift),
    .q       (lfsr)
  );

  // first set request at or after rr_ptr, wrapping
  always_comb begin
    pick  = rr_ptr;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = {1'b0, rr_ptr} + (PW+1)'(i);
      if (idx >= (PW+1)'(N_REQ))
        idx = idx - (PW+1)'(N_REQ);
      if (!found && req[idx[PW-1:0]]) begin
        found = 1'b1;
        pick  = idx[PW-1:0];
      end
    end
  end

  // next state, lfsr control and grant outputs
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    win_n     = winner;
    ptr_n     = rr_ptr;
    load      = 1'b0;
    load_val  = (seed == '0) ? SEED0 : seed;
    shift     = 1'b0;
    err_n     = 1'b0;
    gnt       = '0;
    rnd_valid = 1'b0;
    unique case (state)
      IDLE: begin
        if (seed_we) begin
          load = 1'b1;
        end else if (|req) begin
          win_n   = pick;
          cnt_n   = CW'(STEPS - 1);
          state_n = STEP;
        end
      end
      STEP: begin
        shift = 1'b1;
        err_n = seed_we;
        if (cnt == '0)
          state_n = GRANT;
        else
          cnt_n = cnt - 1'b1;
      end
      GRANT: begin
        err_n   = seed_we;
        state_n = IDLE;
        if (req[winner]) begin
          gnt[winner] = 1'b1;
          rnd_valid   = 1'b1;
          ptr_n = (winner == PW'(N_REQ - 1))
                ? '0 : winner + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // fsm, counter, pointer and output hold registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      winner   <= '0;
      cnt      <= '0;
      rnd_q    <= '0;
      seed_err <= 1'b0;
    end else begin
      state    <= state_n;
      rr_ptr   <= ptr_n;
      winner   <= win_n;
      cnt      <= cnt_n;
      seed_err <= err_n;
      if (rnd_valid)
        rnd_q <= lfsr;
    end
  end

  assign rnd_out = rnd_valid ? lfsr : rnd_q;
  assign busy    = (state != IDLE);

endmodule
